// File: rtl/cam_stream_capture.sv
// Camera byte-stream capture: pairs bytes into Y8 / RGB565 / luma pixels, crops and decimates,
// and queues pixels with SOF/EOL flags into a small FIFO feeding a valid/ready stream.
module cam_stream_capture #(
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int OUT_WIDTH  = 16,
    localparam int XW = $clog2(MAX_WIDTH),
    localparam int YW = $clog2(MAX_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic                 cam_byte_vld,
    input  logic [7:0]           cam_d,
    input  logic [1:0]           cfg_mode,
    input  logic [XW-1:0]        cfg_x0,
    input  logic [YW-1:0]        cfg_y0,
    input  logic [XW-1:0]        cfg_w,
    input  logic [YW-1:0]        cfg_h,
    input  logic [1:0]           cfg_decim,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    // state  | meaning
    // IDLE   | after reset, waiting for the first vsync rise (never start mid-frame)
    // VBLANK | vertical blank, cfg latched when vsync falls
    // ACTIVE | capturing pixels of the current frame
    // DROP   | FIFO overflowed this frame, discard until next vsync rise
    typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE, S_DROP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_MAX    = XW'(MAX_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(MAX_HEIGHT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    state_t state_q, state_d;

    logic vsync_q, href_q;
    logic vs_rise, vs_fall, href_rise, href_fall, frame_start;

    logic [1:0]    mode_q, mode_d;
    logic [XW-1:0] x0_q, x0_d, w_q, w_d;
    logic [YW-1:0] y0_q, y0_d, h_q, h_d;
    logic [1:0]    decim_q, decim_d;

    logic          phase_q, phase_d, phase_eff;
    logic [7:0]    b0_q, b0_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          byte_take, pix_done;

    logic [15:0]   raw, pix16;
    logic [7:0]    r8, g8, b8, luma8;
    logic [9:0]    luma_sum;

    logic [1:0]    dmask;
    logic [XW-1:0] mask_x, dx;
    logic [YW-1:0] mask_y, dy;
    logic [XW:0]   last_x;
    logic          in_x, in_y, on_grid, accept, is_eol;

    logic                 sof_pend_q, sof_pend_d;
    logic                 pv_q, pv_d;
    logic [OUT_WIDTH-1:0] pdata_q, pdata_d;
    logic                 psof_q, psof_d, peol_q, peol_d;

    logic [OUT_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [OUT_WIDTH+1:0] rd_entry;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 full, pop, push, wr_req, ovf_evt;

    logic       overflow_q, overflow_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign vs_rise     = cam_vsync & ~vsync_q;
    assign vs_fall     = ~cam_vsync & vsync_q;
    assign href_rise   = cam_href & ~href_q;
    assign href_fall   = ~cam_href & href_q;
    assign frame_start = (state_q == S_VBLANK) && vs_fall;

    // Byte pairing and pixel coordinates
    assign byte_take = cam_byte_vld && cam_href;
    assign phase_eff = href_rise ? 1'b0 : phase_q;
    assign pix_done  = byte_take && phase_eff;

    always_comb begin
        phase_d = phase_eff;
        b0_d    = b0_q;
        x_d     = href_rise ? '0 : x_q;
        y_d     = y_q;
        if (byte_take) begin
            phase_d = ~phase_eff;
            if (!phase_eff) b0_d = cam_d;
        end
        if (pix_done && x_d != X_MAX) x_d = x_d + XW'(1);
        if (vs_fall) y_d = '0;
        else if (href_fall && y_q != Y_MAX) y_d = y_q + YW'(1);
    end

    // Pixel formatting from the held first byte and the completing byte
    assign raw      = {b0_q, cam_d};
    assign r8       = {raw[15:11], raw[15:13]};
    assign g8       = {raw[10:5], raw[10:9]};
    assign b8       = {raw[4:0], raw[4:2]};
    assign luma_sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
    assign luma8    = 8'(luma_sum >> 2);

    always_comb begin
        case (mode_q)
            2'd1:    pix16 = raw;
            2'd2:    pix16 = {8'h00, luma8};
            default: pix16 = {8'h00, b0_q};
        endcase
    end

    // Crop window and decimation grid
    always_comb begin
        case (decim_q)
            2'd0:    dmask = 2'b00;
            2'd1:    dmask = 2'b01;
            default: dmask = 2'b11;
        endcase
    end

    assign mask_x  = XW'(dmask);
    assign mask_y  = YW'(dmask);
    assign dx      = x_q - x0_q;
    assign dy      = y_q - y0_q;
    assign in_x    = (x_q >= x0_q) && (dx < w_q);
    assign in_y    = (y_q >= y0_q) && (dy < h_q);
    assign on_grid = ((dx & mask_x) == '0) && ((dy & mask_y) == '0);
    assign accept  = pix_done && (state_q == S_ACTIVE) && in_x && in_y && on_grid;
    assign last_x  = {1'b0, x0_q} + {1'b0, (w_q - XW'(1)) & ~mask_x};
    assign is_eol  = ({1'b0, x_q} == last_x);

    always_comb begin
        pv_d       = accept;
        pdata_d    = pdata_q;
        psof_d     = psof_q;
        peol_d     = peol_q;
        sof_pend_d = sof_pend_q;
        if (accept) begin
            pdata_d    = OUT_WIDTH'(pix16);
            psof_d     = sof_pend_q;
            peol_d     = is_eol;
            sof_pend_d = 1'b0;
        end
        if (frame_start) sof_pend_d = 1'b1;
    end

    // FIFO write stage; a simultaneous pop frees the slot on a full FIFO
    assign pop     = out_valid && out_ready;
    assign full    = (cnt_q == CNT_FULL);
    assign wr_req  = pv_q && (state_q != S_DROP);
    assign push    = wr_req && (!full || pop);
    assign ovf_evt = wr_req && full && !pop;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_comb begin
        overflow_d = overflow_q | ovf_evt;
        drop_cnt_d = drop_cnt_q;
        if (ovf_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        decim_d = decim_q;
        case (state_q)
            S_IDLE:   if (vs_rise) state_d = S_VBLANK;
            S_VBLANK: if (vs_fall) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (vs_rise) state_d = S_VBLANK;
                else if (ovf_evt) state_d = S_DROP;
            end
            S_DROP:   if (vs_rise) state_d = S_VBLANK;
            default:  state_d = S_IDLE;
        endcase
        if (frame_start) begin
            mode_d  = cfg_mode;
            x0_d    = cfg_x0;
            y0_d    = cfg_y0;
            w_d     = cfg_w;
            h_d     = cfg_h;
            decim_d = cfg_decim;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b1;
            href_q     <= 1'b0;
            mode_q     <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            decim_q    <= '0;
            phase_q    <= 1'b0;
            b0_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sof_pend_q <= 1'b0;
            pv_q       <= 1'b0;
            pdata_q    <= '0;
            psof_q     <= 1'b0;
            peol_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= cam_vsync;
            href_q     <= cam_href;
            mode_q     <= mode_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            decim_q    <= decim_d;
            phase_q    <= phase_d;
            b0_q       <= b0_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sof_pend_q <= sof_pend_d;
            pv_q       <= pv_d;
            pdata_q    <= pdata_d;
            psof_q     <= psof_d;
            peol_q     <= peol_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {psof_q, peol_q, pdata_q};
    end

    // Outputs read as zero while the FIFO is empty
    assign rd_entry  = mem[rd_ptr_q];
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? rd_entry[OUT_WIDTH-1:0] : '0;
    assign out_sof   = out_valid & rd_entry[OUT_WIDTH+1];
    assign out_eol   = out_valid & rd_entry[OUT_WIDTH];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cam_stream_capture.sv
// Directed bench for cam_stream_capture: drives synthetic camera frames and compares the
// received pixel stream against hand-derived expected values.
`timescale 1ns/1ps
module tb_cam_stream_capture;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          cam_vsync, cam_href, cam_byte_vld;
    logic [7:0]    cam_d;
    logic [1:0]    cfg_mode, cfg_decim;
    logic [XW-1:0] cfg_x0, cfg_w;
    logic [YW-1:0] cfg_y0, cfg_h;
    logic          out_valid, out_ready, out_sof, out_eol, overflow;
    logic [15:0]   out_data;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    cam_stream_capture dut (
        .clk(clk), .rst(rst),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte_vld(cam_byte_vld), .cam_d(cam_d),
        .cfg_mode(cfg_mode), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_decim(cfg_decim),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    int checks = 0;
    int failures = 0;
    logic [17:0] rx[$];

    always @(negedge clk) if (out_valid && out_ready) rx.push_back({out_sof, out_eol, out_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int          pat = 0;
    int          mid_line = -1;
    logic [1:0]  mid_mode = 2'd0;
    int          rst_line = -1;
    int          rst_base = 0;
    logic        lat_chk = 1'b0;
    logic [15:0] luma_tab [4] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};

    function automatic logic [15:0] px_bytes(input int x, input int y);
        if (pat == 1) return luma_tab[x];
        return {8'(x + 16 * y), 8'h80};
    endfunction

    task automatic send_frame(input int npx, input int nlines);
        logic [15:0] w;
        cam_vsync = 1'b1;
        repeat (4) tick;
        cam_vsync = 1'b0;
        repeat (4) tick;
        for (int y = 0; y < nlines; y++) begin
            if (y == mid_line) cfg_mode = mid_mode;
            if (y == rst_line) begin
                chk("rst_pre_valid", 32'(out_valid), 32'd1);
                rst = 1'b1;
                tick;
                rst = 1'b0;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_data", 32'(out_data), 32'd0);
                chk("rst_flags", {30'd0, out_sof, out_eol}, 32'd0);
                chk("rst_ovf", 32'(overflow), 32'd0);
                chk("rst_drop", 32'(drop_cnt), 32'd0);
                out_ready = 1'b1;
                rst_base = rx.size();
            end
            cam_href = 1'b1;
            tick;
            for (int x = 0; x < npx; x++) begin
                w = px_bytes(x, y);
                cam_byte_vld = 1'b1; cam_d = w[15:8]; tick;
                cam_byte_vld = 1'b0; tick;
                cam_byte_vld = 1'b1; cam_d = w[7:0]; tick;
                cam_byte_vld = 1'b0;
                if (lat_chk && x == 0 && y == 0) chk("lat_n1", 32'(out_valid), 32'd0);
                tick;
                if (lat_chk && x == 0 && y == 0) chk("lat_n2", 32'(out_valid), 32'd1);
            end
            cam_href = 1'b0;
            repeat (4) tick;
        end
    endtask

    task automatic drain(input int target);
        for (int i = 0; i < 400 && rx.size() < target; i++) tick;
        repeat (20) tick;
    endtask

    task automatic exp_px(input string tag, input int idx, input logic sof, input logic eol,
                          input logic [15:0] d);
        chk(tag, (idx < rx.size()) ? 32'(rx[idx]) : 32'hFFFF_FFFF, {14'd0, sof, eol, d});
    endtask

    // Full 8x4 frame, no crop: pixel (x,y) carries first byte x+16*y
    task automatic check_full(input string tag, input int base, input int n, input logic rgb);
        for (int i = 0; i < n; i++) begin
            int x = i % 8;
            int y = i / 8;
            logic [7:0] yv = 8'(x + 16 * y);
            exp_px(tag, base + i, i == 0, x == 7, rgb ? {yv, 8'h80} : {8'h00, yv});
        end
    endtask

    task automatic set_full_cfg(input logic [1:0] mode);
        cfg_mode = mode; cfg_x0 = '0; cfg_y0 = '0; cfg_w = 10'd8; cfg_h = 9'd4; cfg_decim = 2'd0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        cam_vsync = 1'b0; cam_href = 1'b0; cam_byte_vld = 1'b0; cam_d = '0;
        out_ready = 1'b1;
        set_full_cfg(2'd0);
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_sof", 32'(out_sof), 32'd0);
        chk("reset_eol", 32'(out_eol), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_drop", 32'(drop_cnt), 32'd0);

        // Y8 full frame
        base = rx.size();
        lat_chk = 1'b1;
        send_frame(8, 4);
        lat_chk = 1'b0;
        drain(base + 32);
        chk("y8_cnt", rx.size() - base, 32'd32);
        check_full("y8_px", base, 32, 1'b0);

        // RGB565 -> luma
        cfg_mode = 2'd2; cfg_w = 10'd4; cfg_h = 9'd1;
        pat = 1;
        base = rx.size();
        send_frame(4, 1);
        pat = 0;
        drain(base + 4);
        chk("luma_cnt", rx.size() - base, 32'd4);
        exp_px("luma_ffff", base + 0, 1'b1, 1'b0, 16'h00FF);
        exp_px("luma_f800", base + 1, 1'b0, 1'b0, 16'h003F);
        exp_px("luma_07e0", base + 2, 1'b0, 1'b0, 16'h007F);
        exp_px("luma_001f", base + 3, 1'b0, 1'b1, 16'h003F);

        // Crop with 1:2 decimation
        cfg_mode = 2'd0; cfg_x0 = 10'd2; cfg_y0 = 9'd1; cfg_w = 10'd4; cfg_h = 9'd3; cfg_decim = 2'd1;
        base = rx.size();
        send_frame(8, 4);
        drain(base + 4);
        chk("crop_cnt", rx.size() - base, 32'd4);
        exp_px("crop_2_1", base + 0, 1'b1, 1'b0, 16'h0012);
        exp_px("crop_4_1", base + 1, 1'b0, 1'b1, 16'h0014);
        exp_px("crop_2_3", base + 2, 1'b0, 1'b0, 16'h0032);
        exp_px("crop_4_3", base + 3, 1'b0, 1'b1, 16'h0034);

        // Overflow with ready held low for a whole frame
        set_full_cfg(2'd0);
        out_ready = 1'b0;
        base = rx.size();
        send_frame(8, 4);
        repeat (10) tick;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd1);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_none_out", rx.size() - base, 32'd0);
        out_ready = 1'b1;
        drain(base + 16);
        chk("ovf_drain_cnt", rx.size() - base, 32'd16);
        check_full("ovf_drain_px", base, 16, 1'b0);
        base = rx.size();
        send_frame(8, 4);
        drain(base + 32);
        chk("ovf_next_cnt", rx.size() - base, 32'd32);
        check_full("ovf_next_px", base, 32, 1'b0);
        chk("ovf_drop_hold", 32'(drop_cnt), 32'd1);

        // Mode change mid-frame takes effect on the next frame only
        set_full_cfg(2'd1);
        mid_line = 2; mid_mode = 2'd0;
        base = rx.size();
        send_frame(8, 4);
        mid_line = -1;
        drain(base + 32);
        chk("mode_rgb_cnt", rx.size() - base, 32'd32);
        check_full("mode_rgb_px", base, 32, 1'b1);
        base = rx.size();
        send_frame(8, 4);
        drain(base + 32);
        chk("mode_y8_cnt", rx.size() - base, 32'd32);
        check_full("mode_y8_px", base, 32, 1'b0);

        // Reset during line 2 with a full FIFO
        out_ready = 1'b0;
        rst_line = 2;
        send_frame(8, 4);
        rst_line = -1;
        repeat (20) tick;
        chk("rst_no_out", rx.size() - rst_base, 32'd0);
        base = rx.size();
        send_frame(8, 4);
        drain(base + 32);
        chk("rst_next_cnt", rx.size() - base, 32'd32);
        check_full("rst_next_px", base, 32, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
